// File: rtl/store_drain_ctrl_pkg.sv
// rtl/store_drain_ctrl_pkg.sv - shared types and requester indices for the store drain sequencer
//
// Purpose: FSM state encoding and the fixed requester slot assignment used by
//          store_drain_ctrl, its arbiter, and the requesters that connect to it.
// Ports:   none (package).

package store_drain_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } drain_state_e;

    // Requester slot assignment on req_i / req_full_i / gnt_o.
    localparam int DRAIN_FENCE = 0;
    localparam int DRAIN_AMO   = 1;
    localparam int DRAIN_CSR   = 2;
    localparam int DRAIN_LOAD  = 3;

endpackage

// File: rtl/store_drain_ctrl_arbiter.sv
// rtl/store_drain_ctrl_arbiter.sv - combinational round-robin pick for drain requesters
//
// Purpose: selects the first set request bit at or after ptr, wrapping around.
// Ports:
//   req   in  NR_REQ  request vector
//   ptr   in  IDX_W   highest-priority index for this pick
//   idx   out IDX_W   winning index (0 when valid is low)
//   valid out 1       at least one request is set

module drain_rr_arbiter #(
    parameter int NR_REQ = 4,
    localparam int IDX_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1
) (
    input  logic [NR_REQ-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [IDX_W-1:0]  idx,
    output logic              valid
);

    logic [IDX_W:0] w_pos;

    // Walk the requesters in priority order; the first hit wins.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        w_pos = '0;
        for (int i = 0; i < NR_REQ; i++) begin
            w_pos = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (w_pos >= (IDX_W + 1)'(NR_REQ)) begin
                w_pos = w_pos - (IDX_W + 1)'(NR_REQ);
            end
            if (!valid && req[w_pos[IDX_W-1:0]]) begin
                valid = 1'b1;
                idx   = w_pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/store_drain_ctrl.sv
// rtl/store_drain_ctrl.sv - store buffer drain sequencer with round-robin grant and watchdog
//
// Purpose: accepts drain requests (fence, AMO, CSR write, load hazard), blocks
//          further commits while draining, waits for the requested emptiness
//          level and then grants exactly one requester for one cycle.
// Ports:
//   clk_i                in  1       clock
//   rst_i                in  1       synchronous active-high reset
//   req_i                in  NR_REQ  level drain request per requester
//   req_full_i           in  NR_REQ  1 = wait for whole buffer empty, 0 = commit queue only
//   gnt_o                out NR_REQ  one-hot one-cycle drain-complete grant
//   no_st_pending_i      in  1       commit queue empty
//   store_buffer_empty_i in  1       speculative and commit queues empty
//   block_commit_o       out 1       commit stage must hold off commit_i
//   busy_o               out 1       sequencer not idle
//   timeout_o            out 1       sticky watchdog flag
//   timeout_clr_i        in  1       clears timeout_o (wins over a same-cycle set)

module store_drain_ctrl
    import store_drain_ctrl_pkg::*;
#(
    parameter int NR_REQ    = 4,
    parameter int TIMEOUT_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NR_REQ-1:0] req_i,
    input  logic [NR_REQ-1:0] req_full_i,
    output logic [NR_REQ-1:0] gnt_o,
    input  logic              no_st_pending_i,
    input  logic              store_buffer_empty_i,
    output logic              block_commit_o,
    output logic              busy_o,
    output logic              timeout_o,
    input  logic              timeout_clr_i
);

    localparam int IDX_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
    localparam logic [TIMEOUT_W-1:0] WD_MAX = '1;

    drain_state_e         r_state;
    drain_state_e         w_state_nxt;
    logic [IDX_W-1:0]     r_rr_ptr;
    logic [IDX_W-1:0]     r_win;
    logic                 r_full;
    logic [TIMEOUT_W-1:0] r_wd;
    logic                 r_timeout;

    logic [IDX_W-1:0]     w_arb_idx;
    logic                 w_arb_valid;
    logic                 w_drain_ok;
    logic                 w_wd_hit_max;

    drain_rr_arbiter #(
        .NR_REQ (NR_REQ)
    ) u_arb (
        .req   (req_i),
        .ptr   (r_rr_ptr),
        .idx   (w_arb_idx),
        .valid (w_arb_valid)
    );

    assign w_drain_ok   = r_full ? store_buffer_empty_i : no_st_pending_i;
    // Flag is raised only on the step into saturation, so clearing it while
    // the drain is still stuck does not immediately re-arm it.
    assign w_wd_hit_max = (r_state == DRAIN) && (r_wd == WD_MAX - TIMEOUT_W'(1));

    always_comb begin
        w_state_nxt    = r_state;
        gnt_o          = '0;
        block_commit_o = 1'b0;
        busy_o         = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (|req_i) w_state_nxt = ARB;
            end
            ARB: begin
                // Requests may vanish before arbitration; fall back without latching.
                w_state_nxt = w_arb_valid ? DRAIN : IDLE;
            end
            DRAIN: begin
                block_commit_o = 1'b1;
                if (w_drain_ok) w_state_nxt = DONE;
            end
            DONE: begin
                block_commit_o = 1'b1;
                gnt_o[r_win]   = 1'b1;
                w_state_nxt    = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_rr_ptr  <= '0;
            r_win     <= '0;
            r_full    <= 1'b0;
            r_wd      <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (r_state == ARB && w_arb_valid) begin
                r_win  <= w_arb_idx;
                r_full <= req_full_i[w_arb_idx];
            end

            if (r_state == DRAIN && r_wd != WD_MAX) begin
                r_wd <= r_wd + TIMEOUT_W'(1);
            end else if (r_state == DONE) begin
                r_wd     <= '0;
                r_rr_ptr <= (r_win == IDX_W'(NR_REQ - 1)) ? '0 : r_win + IDX_W'(1);
            end

            if (timeout_clr_i) begin
                r_timeout <= 1'b0;
            end else if (w_wd_hit_max) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout_o = r_timeout;

endmodule

// File: tb/tb_store_drain_ctrl.sv
// tb/tb_store_drain_ctrl.sv - scoreboard testbench for store_drain_ctrl

module tb_store_drain_ctrl;
    import store_drain_ctrl_pkg::*;

    typedef struct {
        int         cyc;
        logic [3:0] gnt;
    } exp_t;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [3:0] req_i;
    logic [3:0] req_full_i;
    logic [3:0] gnt_o;
    logic       no_st_pending_i;
    logic       store_buffer_empty_i;
    logic       block_commit_o;
    logic       busy_o;
    logic       timeout_o;
    logic       timeout_clr_i;

    int   cyc   = 0;
    int   base  = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    exp_t m_e;

    store_drain_ctrl #(
        .NR_REQ    (4),
        .TIMEOUT_W (3)
    ) dut (
        .clk_i                (clk_i),
        .rst_i                (rst_i),
        .req_i                (req_i),
        .req_full_i           (req_full_i),
        .gnt_o                (gnt_o),
        .no_st_pending_i      (no_st_pending_i),
        .store_buffer_empty_i (store_buffer_empty_i),
        .block_commit_o       (block_commit_o),
        .busy_o               (busy_o),
        .timeout_o            (timeout_o),
        .timeout_clr_i        (timeout_clr_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc - base);
        end
    endtask

    task automatic at(input int k);
        while (cyc < base + k) @(negedge clk_i);
    endtask

    task automatic push(input int k, input logic [3:0] g);
        exp_t e;
        e.cyc = base + k;
        e.gnt = g;
        sb.push_back(e);
    endtask

    // Grant monitor: every nonzero gnt_o must match the oldest expected grant.
    always @(negedge clk_i) begin
        if (gnt_o !== 4'b0000) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_gnt: got %b at cycle %0d, expected no grant", gnt_o, cyc);
            end else begin
                m_e = sb.pop_front();
                if (gnt_o !== m_e.gnt || cyc != m_e.cyc) begin
                    bad++;
                    $display("FAIL gnt: got %b at cycle %0d, expected %b at cycle %0d",
                             gnt_o, cyc, m_e.gnt, m_e.cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        rst_i                = 1'b1;
        req_i                = 4'b0000;
        req_full_i           = 4'b0000;
        no_st_pending_i      = 1'b1;
        store_buffer_empty_i = 1'b1;
        timeout_clr_i        = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("rst_gnt", gnt_o, 0);
        chk("rst_blk", block_commit_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_tmo", timeout_o, 0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Single fence, commit queue already empty
        base = cyc;
        req_i[DRAIN_FENCE] = 1'b1;
        push(3, 4'b0001);
        at(1); chk("t1_blk_c1", block_commit_o, 0); chk("t1_busy_c1", busy_o, 1);
        at(2); chk("t1_blk_c2", block_commit_o, 1);
        at(3); chk("t1_blk_c3", block_commit_o, 1); req_i = 4'b0000;
        at(4); chk("t1_busy_c4", busy_o, 0); chk("t1_blk_c4", block_commit_o, 0);

        // Pending stores hold the drain; clear wins over the watchdog set
        at(5);
        base = cyc;
        req_i[DRAIN_FENCE] = 1'b1;
        no_st_pending_i = 1'b0;
        push(10, 4'b0001);
        for (int k = 2; k <= 10; k++) begin
            at(k);
            chk("t2_blk", block_commit_o, 1);
            if (k == 8) timeout_clr_i = 1'b1;
            if (k == 9) begin
                timeout_clr_i   = 1'b0;
                no_st_pending_i = 1'b1;
                chk("t2_tmo_clr_prio", timeout_o, 0);
            end
            if (k == 10) begin
                req_i = 4'b0000;
                chk("t2_tmo_c10", timeout_o, 0);
            end
        end
        at(11); chk("t2_busy_c11", busy_o, 0);

        // Full drain (AMO) waits on store_buffer_empty_i, not no_st_pending_i
        at(12);
        base = cyc;
        req_i[DRAIN_AMO]      = 1'b1;
        req_full_i[DRAIN_AMO] = 1'b1;
        store_buffer_empty_i  = 1'b0;
        push(7, 4'b0010);
        at(4); chk("t3_blk_c4", block_commit_o, 1); chk("t3_busy_c4", busy_o, 1);
        at(6); store_buffer_empty_i = 1'b1;
        at(7); req_i = 4'b0000; req_full_i = 4'b0000;
        at(8); chk("t3_busy_c8", busy_o, 0);

        // Watchdog sets, sticks, clears; then reset mid-drain
        at(9);
        base = cyc;
        req_i[DRAIN_CSR] = 1'b1;
        no_st_pending_i  = 1'b0;
        at(8);  chk("t4_tmo_c8", timeout_o, 0);
        at(9);  chk("t4_tmo_c9", timeout_o, 1);
        at(12); chk("t4_tmo_c12", timeout_o, 1); chk("t4_busy_c12", busy_o, 1);
        chk("t4_blk_c12", block_commit_o, 1);
        timeout_clr_i = 1'b1;
        at(13); timeout_clr_i = 1'b0;
        chk("t4_tmo_clr", timeout_o, 0); chk("t4_busy_c13", busy_o, 1);
        rst_i = 1'b1; req_i = 4'b0000;
        at(14);
        chk("t5_rst_gnt", gnt_o, 0); chk("t5_rst_blk", block_commit_o, 0);
        chk("t5_rst_busy", busy_o, 0); chk("t5_rst_tmo", timeout_o, 0);
        rst_i = 1'b0; no_st_pending_i = 1'b1;

        // Round-robin over all four, pointer starts at 0 after reset
        at(15);
        base  = cyc;
        req_i = 4'b1111;
        push(3, 4'b0001); push(7, 4'b0010); push(11, 4'b0100); push(15, 4'b1000);
        for (int g = 0; g < 4; g++) begin
            at(3 + 4 * g);
            req_i[g] = 1'b0;
        end

        // Pointer wrapped to 0: requester 0 before 3
        at(16);
        base  = cyc;
        req_i = 4'b1001;
        push(3, 4'b0001); push(7, 4'b1000);
        at(3); req_i[DRAIN_FENCE] = 1'b0;
        at(7); req_i[DRAIN_LOAD]  = 1'b0;
        at(8); chk("t6_busy_c8", busy_o, 0); chk("t6_blk_c8", block_commit_o, 0);

        at(12);
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
